// File: rtl/note_event_sync_pkg.sv
// note_event_sync_pkg: shared event record, event-type constants and default widths for the note-event front end
package note_event_sync_pkg;
    localparam int DEF_VOICES     = 8;
    localparam int DEF_V_WIDTH    = $clog2(DEF_VOICES);
    localparam int DEF_E_WIDTH    = 3;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_FL_WIDTH   = $clog2(DEF_FIFO_DEPTH) + 1;
    localparam int DEF_VEL_WIDTH  = 8;
    localparam int DEF_LVL_WIDTH  = 8;
    localparam logic EV_NOTE_ON  = 1'b1;
    localparam logic EV_NOTE_OFF = 1'b0;
    typedef struct packed {
        logic                     typ;
        logic [DEF_V_WIDTH-1:0]   adr;
        logic [7:0]               key;
        logic [DEF_VEL_WIDTH-1:0] vel;
    } ev_t;
endpackage

// File: rtl/note_event_fifo.sv
// note_event_fifo: event FIFO with occupancy, full/empty and sticky drop flag
module note_event_fifo import note_event_sync_pkg::*; #(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        OSC_CLK,
    input  logic        reset_reg_N,
    input  logic        valid,
    output logic        ready,
    input  ev_t         din,
    input  logic        pop,
    output ev_t         dout,
    output logic [AW:0] level,
    output logic        empty,
    input  logic        ovf_clr,
    output logic        ovf
);
    ev_t mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic full, push, do_pop;
    assign full   = level == (AW+1)'(DEPTH);
    assign empty  = level == '0;
    assign ready  = !full;
    assign push   = valid && !full;
    assign do_pop = pop && !empty;
    assign dout   = mem[rd];
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr    <= '0;
            rd    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(do_pop);
            // a drop in the same cycle as a clear keeps the flag set
            ovf   <= (valid && full) || (ovf && !ovf_clr);
        end
    end
    always_ff @(posedge OSC_CLK) begin
        if (push) mem[wr] <= din;
    end
endmodule

// File: rtl/note_event_sync.sv
// note_event_sync: frame-synchronous note-event release with note-on pulse pipeline and velocity-scaled level
// VEL_CURVE_EN: square the stored note-on velocity (one extra cycle on the velocity write)
module note_event_sync import note_event_sync_pkg::*; #(
    parameter int VOICES     = DEF_VOICES,
    parameter int V_WIDTH    = $clog2(VOICES),
    parameter int E_WIDTH    = DEF_E_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int VEL_WIDTH  = DEF_VEL_WIDTH,
    parameter int LVL_WIDTH  = DEF_LVL_WIDTH,
    parameter int NOTE_DLY   = 3
) (
    input  logic                         OSC_CLK,
    input  logic                         reset_reg_N,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_type,
    input  logic [V_WIDTH-1:0]           ev_key_adr,
    input  logic [7:0]                   ev_key_val,
    input  logic [VEL_WIDTH-1:0]         ev_vel,
    input  logic [VOICES-1:0]            keys_on,
    input  logic                         n_xxxx_zero,
    input  logic [V_WIDTH+E_WIDTH-1:0]   xxxx,
    input  logic [LVL_WIDTH-1:0]         level_mul,
    input  logic                         ovf_clr,
    output logic                         note_on_out,
    output logic                         note_on_dly,
    output logic [V_WIDTH-1:0]           key_adr,
    output logic [7:0]                   key_val,
    output logic [VEL_WIDTH-1:0]         vel_on,
    output logic [VOICES-1:0]            keys_on_out,
    output logic [LVL_WIDTH-1:0]         level_mul_vel,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         ovf
);
    localparam int PW = VEL_WIDTH + LVL_WIDTH;
    ev_t ev_in, ev_out;
    logic fifo_empty, tick, pop;
    logic [2:0] sync;
    logic [NOTE_DLY:0] sr;
    logic [VEL_WIDTH-1:0] vel_on_mem [VOICES];
    logic [VEL_WIDTH-1:0] vel_off_mem [VOICES];
    logic wr_en;
    logic [V_WIDTH-1:0] wr_adr;
    logic [VEL_WIDTH-1:0] wr_vel;
    logic [PW-1:0] p;
    assign ev_in = '{typ: ev_type, adr: ev_key_adr, key: ev_key_val, vel: ev_vel};
    assign pop = tick && !fifo_empty;
    assign note_on_out = sr[NOTE_DLY-1];
    assign note_on_dly = sr[NOTE_DLY];
    note_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .OSC_CLK(OSC_CLK), .reset_reg_N(reset_reg_N),
        .valid(ev_valid), .ready(ev_ready), .din(ev_in),
        .pop(pop), .dout(ev_out), .level(fifo_level), .empty(fifo_empty),
        .ovf_clr(ovf_clr), .ovf(ovf)
    );
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            sync        <= '1;
            tick        <= 1'b0;
            sr          <= '0;
            key_adr     <= '0;
            key_val     <= '0;
            vel_on      <= '0;
            keys_on_out <= '0;
        end else begin
            sync <= {sync[1:0], n_xxxx_zero};
            tick <= sync[2] && !sync[1];
            sr   <= {sr[NOTE_DLY-1:0], pop && ev_out.typ == EV_NOTE_ON};
            if (tick) keys_on_out <= keys_on;
            if (pop) begin
                key_adr <= ev_out.adr;
                key_val <= ev_out.key;
                vel_on  <= ev_out.vel;
            end
        end
    end
`ifdef VEL_CURVE_EN
    logic [2*VEL_WIDTH-1:0] sq;
    assign sq = (2*VEL_WIDTH)'(ev_out.vel) * (2*VEL_WIDTH)'(ev_out.vel);
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            wr_en  <= 1'b0;
            wr_adr <= '0;
            wr_vel <= '0;
        end else begin
            wr_en  <= pop && ev_out.typ == EV_NOTE_ON;
            wr_adr <= ev_out.adr;
            wr_vel <= &ev_out.vel ? '1 : sq[2*VEL_WIDTH-1:VEL_WIDTH];
        end
    end
`else
    assign wr_en  = pop && ev_out.typ == EV_NOTE_ON;
    assign wr_adr = ev_out.adr;
    assign wr_vel = ev_out.vel;
`endif
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int i = 0; i < VOICES; i++) begin
                vel_on_mem[i]  <= '1;
                vel_off_mem[i] <= '1;
            end
        end else begin
            if (wr_en) vel_on_mem[wr_adr] <= wr_vel;
            if (pop && ev_out.typ == EV_NOTE_OFF) vel_off_mem[ev_out.adr] <= ev_out.vel;
        end
    end
    assign p = PW'(vel_on_mem[xxxx[V_WIDTH+E_WIDTH-1:E_WIDTH]]) * PW'(level_mul);
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) level_mul_vel <= '0;
        else level_mul_vel <= |p[PW-1:VEL_WIDTH-1+LVL_WIDTH] ? '1 : p[VEL_WIDTH-1 +: LVL_WIDTH];
    end
endmodule

// File: tb/tb_note_event_sync.sv
// tb_note_event_sync: scoreboard bench with a queue-based event model and arithmetic level model
module tb_note_event_sync;
    logic OSC_CLK = 0, reset_reg_N = 0, ev_valid = 0, ev_type = 0, ovf_clr = 0, n_xxxx_zero = 1;
    logic [2:0] ev_key_adr = 0;
    logic [7:0] ev_key_val = 0, ev_vel = 0, keys_on = 0, level_mul = 0;
    logic [5:0] xxxx = 0;
    logic ev_ready, note_on_out, note_on_dly, ovf;
    logic [2:0] key_adr, fifo_level;
    logic [7:0] key_val, vel_on, keys_on_out, level_mul_vel;

    note_event_sync dut (
        .OSC_CLK(OSC_CLK), .reset_reg_N(reset_reg_N), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_type(ev_type), .ev_key_adr(ev_key_adr), .ev_key_val(ev_key_val), .ev_vel(ev_vel),
        .keys_on(keys_on), .n_xxxx_zero(n_xxxx_zero), .xxxx(xxxx), .level_mul(level_mul),
        .ovf_clr(ovf_clr), .note_on_out(note_on_out), .note_on_dly(note_on_dly),
        .key_adr(key_adr), .key_val(key_val), .vel_on(vel_on), .keys_on_out(keys_on_out),
        .level_mul_vel(level_mul_vel), .fifo_level(fifo_level), .ovf(ovf)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    typedef struct {bit on; int adr; int key; int vel;} tev_t;
    tev_t exp_q[$];
    int vel_m[8];
    bit ovf_m, mon_en = 1;
    int last_adr, last_key, last_vel;
    int tests = 0, fails = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int curve(int v);
`ifdef VEL_CURVE_EN
        return v == 255 ? 255 : (v * v) >> 8;
`else
        return v;
`endif
    endfunction

    function automatic int scale(int v, int l);
        int r = (v * l) >> 7;
        return r > 255 ? 255 : r;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        ovf_m = 0;
        last_adr = 0; last_key = 0; last_vel = 0;
        for (int i = 0; i < 8; i++) vel_m[i] = 255;
    endfunction

    // Monitor: each frame boundary releases the oldest modelled event (if any)
    always @(negedge n_xxxx_zero) if (mon_en) begin : mon
        tev_t e;
        bit on;
        on = 0;
        repeat (4) @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            on = e.on;
            last_adr = e.adr; last_key = e.key; last_vel = e.vel;
            if (e.on) vel_m[e.adr] = curve(e.vel);
        end
        check("key_adr", key_adr, last_adr);
        check("key_val", key_val, last_key);
        check("vel_on", vel_on, last_vel);
        check("keys_on_out", keys_on_out, keys_on);
        check("fifo_level_pop", fifo_level, exp_q.size());
        for (int k = 5; k <= 8; k++) begin
            @(posedge OSC_CLK);
            @(negedge OSC_CLK);
            check("note_on_out", note_on_out, on && k == 6);
            check("note_on_dly", note_on_dly, on && k == 7);
        end
    end

    task automatic push_ev(bit on, int adr, int key, int vel);
        @(negedge OSC_CLK);
        check("ev_ready", ev_ready, exp_q.size() < 4);
        ev_valid = 1; ev_type = on; ev_key_adr = 3'(adr); ev_key_val = 8'(key); ev_vel = 8'(vel);
        @(posedge OSC_CLK);
        if (exp_q.size() < 4) exp_q.push_back('{on, adr, key, vel});
        else ovf_m = 1;
    endtask

    task automatic idle();
        @(negedge OSC_CLK);
        ev_valid = 0;
    endtask

    task automatic frame();
        @(negedge OSC_CLK);
        n_xxxx_zero = 0;
        repeat (2) @(negedge OSC_CLK);
        n_xxxx_zero = 1;
        repeat (12) @(negedge OSC_CLK);
    endtask

    task automatic ovf_check_clear();
        check("ovf", ovf, ovf_m);
        if (ovf_m) begin
            ovf_clr = 1;
            @(negedge OSC_CLK);
            ovf_clr = 0;
            ovf_m = 0;
            check("ovf_cleared", ovf, 0);
        end
    endtask

    task automatic lvl_check(int v, int l);
        @(negedge OSC_CLK);
        xxxx = {3'(v), 3'($urandom_range(0, 7))};
        level_mul = 8'(l);
        repeat (2) @(negedge OSC_CLK);
        check("level_mul_vel", level_mul_vel, scale(vel_m[v], l));
    endtask

    initial begin
        bit seen;
        model_reset();
        repeat (3) @(negedge OSC_CLK);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_ev_ready", ev_ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_key_adr", key_adr, 0);
        check("rst_key_val", key_val, 0);
        check("rst_vel_on", vel_on, 0);
        check("rst_keys_on_out", keys_on_out, 0);
        check("rst_level_mul_vel", level_mul_vel, 0);
        check("rst_note_on", {note_on_out, note_on_dly}, 0);
        reset_reg_N = 1;

        // single note-on
        keys_on = 8'hA5;
        push_ev(1, 3, 60, 8'h40);
        idle();
        frame();

        // three events released over three frames in order
        push_ev(1, 1, 61, 8'h21);
        push_ev(0, 4, 62, 8'h22);
        push_ev(1, 6, 63, 8'h23);
        idle();
        check("fifo_level3", fifo_level, 3);
        repeat (3) frame();

        // overflow, clear, and drop-versus-clear priority
        for (int i = 0; i < 5; i++) push_ev(1, i, 70 + i, 10 + i);
        idle();
        check("ev_ready_full", ev_ready, 0);
        ovf_check_clear();
        ev_valid = 1; ovf_clr = 1;
        @(negedge OSC_CLK);
        ev_valid = 0; ovf_clr = 0;
        check("ovf_drop_wins", ovf, 1);
        ovf_m = 1;
        ovf_check_clear();
        repeat (4) frame();

        // level scaling
        push_ev(1, 2, 64, 8'h80);
        idle();
        frame();
        lvl_check(2, 8'h80);

        // note-off leaves the note-on velocity untouched
        push_ev(0, 5, 65, 8'h11);
        idle();
        frame();
        lvl_check(5, 8'h90);

        // randomized phases
        for (int ph = 0; ph < 20; ph++) begin
            int n;
            n = $urandom_range(0, 5);
            @(negedge OSC_CLK);
            keys_on = 8'($urandom);
            for (int i = 0; i < n; i++)
                push_ev($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 255));
            idle();
            ovf_check_clear();
            check("fifo_level", fifo_level, exp_q.size());
            repeat ($urandom_range(1, 3)) frame();
            lvl_check($urandom_range(0, 7), $urandom_range(0, 255));
        end

        // reset with events queued and a pulse in flight
        repeat (4) frame();
        push_ev(1, 1, 80, 8'h50);
        push_ev(0, 2, 81, 8'h30);
        idle();
        mon_en = 0;
        n_xxxx_zero = 0;
        repeat (5) @(posedge OSC_CLK);
        @(negedge OSC_CLK);
        reset_reg_N = 0;
        n_xxxx_zero = 1;
        #1;
        check("rst2_fifo_level", fifo_level, 0);
        check("rst2_ev_ready", ev_ready, 1);
        check("rst2_level_mul_vel", level_mul_vel, 0);
        model_reset();
        @(negedge OSC_CLK);
        reset_reg_N = 1;
        seen = 0;
        repeat (6) begin
            @(negedge OSC_CLK);
            seen |= note_on_out | note_on_dly;
        end
        check("no_pulse_after_reset", seen, 0);
        check("rst2_key_adr", key_adr, 0);
        mon_en = 1;
        lvl_check($urandom_range(0, 7), 8'hFF);
        push_ev(1, 7, 90, 8'hFF);
        idle();
        frame();
        lvl_check(7, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
